ebpf_fetch_unit: RTL and testbench

Instruction fetch front end: the initiator that reads 64-bit eBPF instruction slots from the asynchronous-read program memory. It keeps the program counter and splits each slot into opcode/src/dst/offset/imm. It merges the two-slot LDDW into one instruction, accepts branch redirects from execute, and stops on EXIT. It feeds execute through a one-entry valid/ready output register.

---
 rtl/ebpf_fetch_unit_pkg.sv | 37 +++
 rtl/ebpf_fetch_unit_if.sv | 42 ++++
 rtl/ebpf_fetch_unit_slot_decode.sv | 23 ++
 rtl/ebpf_fetch_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_ebpf_fetch_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ebpf_fetch_unit_pkg.sv
// Shared definitions for the eBPF fetch front end: slot field positions,
// the opcodes the fetcher must recognise, and the fetch FSM state type.
package ebpf_pkg;

  localparam int SLOT_W = 64;

  // Field positions inside one 64-bit instruction slot
  localparam int OPC_HI = 63;
  localparam int OPC_LO = 56;
  localparam int SRC_HI = 55;
  localparam int SRC_LO = 52;
  localparam int DST_HI = 51;
  localparam int DST_LO = 48;
  localparam int OFF_HI = 47;
  localparam int OFF_LO = 32;
  localparam int IMM_HI = 31;
  localparam int IMM_LO = 0;

  // Opcodes that change how the fetcher walks the program
  localparam logic [7:0] OP_LDDW = 8'h18;
  localparam logic [7:0] OP_EXIT = 8'h95;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_FETCH_HI = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_HALT     = 3'd4,
    ST_FAULT    = 3'd5
  } fetch_state_t;

  // Immediates of single-slot instructions are sign-extended to 64 bits
  function automatic logic [63:0] sext_imm(input logic [31:0] imm);
    return {{32{imm[31]}}, imm};
  endfunction

endpackage

// File: rtl/ebpf_fetch_unit_if.sv
// Instruction channel from fetch to execute.
//
// Handshake: the master raises insn_valid with all insn_* fields stable and
// keeps them unchanged until the cycle in which insn_ready is also high; that
// cycle is the transfer. The slave may drive insn_ready independently of
// insn_valid. Only a branch redirect or reset may withdraw a valid instruction.
interface ebpf_fetch_unit_if #(
  parameter int address_size = 12
) ();

  logic                    insn_valid;
  logic                    insn_ready;
  logic [7:0]              insn_opcode;
  logic [3:0]              insn_src;
  logic [3:0]              insn_dst;
  logic [15:0]             insn_offset;
  logic [63:0]             insn_imm;
  logic [address_size-1:0] insn_pc;

  modport master (
    output insn_valid,
    output insn_opcode,
    output insn_src,
    output insn_dst,
    output insn_offset,
    output insn_imm,
    output insn_pc,
    input  insn_ready
  );

  modport slave (
    input  insn_valid,
    input  insn_opcode,
    input  insn_src,
    input  insn_dst,
    input  insn_offset,
    input  insn_imm,
    input  insn_pc,
    output insn_ready
  );

endinterface

// File: rtl/ebpf_fetch_unit_slot_decode.sv
// Combinational split of one instruction slot into its fields. The raw
// 32-bit immediate is kept alongside the sign-extended one so LDDW can
// concatenate two low halves.
module ebpf_slot_decode
  import ebpf_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  output logic [7:0]        opcode,
  output logic [3:0]        src,
  output logic [3:0]        dst,
  output logic [15:0]       offset,
  output logic [31:0]       imm_raw,
  output logic [63:0]       imm_sext
);

  assign opcode   = slot[OPC_HI:OPC_LO];
  assign src      = slot[SRC_HI:SRC_LO];
  assign dst      = slot[DST_HI:DST_LO];
  assign offset   = slot[OFF_HI:OFF_LO];
  assign imm_raw  = slot[IMM_HI:IMM_LO];
  assign imm_sext = sext_imm(slot[IMM_HI:IMM_LO]);

endmodule

// File: rtl/ebpf_fetch_unit.sv
// eBPF instruction fetch front end. Walks program memory from start_pc,
// merges two-slot LDDW, follows redirects from execute, stops at EXIT and
// refuses to run past the last slot. Output is a one-entry valid/ready
// register on the insn interface.
module ebpf_fetch_unit
  import ebpf_pkg::*;
#(
  parameter int data_size    = 64,
  parameter int address_size = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [address_size-1:0] start_pc,
  output logic [address_size-1:0] mem_address,
  input  logic [data_size-1:0]    mem_data,
  input  logic                    redirect_valid,
  input  logic [address_size-1:0] redirect_pc,
  output logic                    halted,
  output logic                    fault,
  output fetch_state_t            state_dbg,
  ebpf_fetch_unit_if.master       insn
);

  // pc carries one extra bit so "next slot" arithmetic can see the end of
  // memory instead of wrapping to slot 0.
  localparam logic [address_size:0] MEM_DEPTH = {1'b1, {address_size{1'b0}}};
  localparam logic [address_size:0] PC_ONE    = 1;
  localparam logic [address_size:0] PC_TWO    = 2;

  fetch_state_t            state;
  logic [address_size:0]   pc;
  logic [address_size:0]   pc_plus1;
  logic [address_size:0]   pc_plus2;

  // Output register
  logic                    valid_q;
  logic [7:0]              opc_q;
  logic [3:0]              src_q;
  logic [3:0]              dst_q;
  logic [15:0]             off_q;
  logic [63:0]             imm_q;
  logic [address_size-1:0] ipc_q;

  // First slot of an LDDW, held while the second slot is read
  logic [3:0]              lo_src;
  logic [3:0]              lo_dst;
  logic [15:0]             lo_off;
  logic [31:0]             lo_imm;

  logic                    halted_q;
  logic                    fault_q;

  // Decoded view of the slot currently on mem_data
  logic [7:0]              d_opc;
  logic [3:0]              d_src;
  logic [3:0]              d_dst;
  logic [15:0]             d_off;
  logic [31:0]             d_imm_raw;
  logic [63:0]             d_imm_sext;

  logic                    xfer;
  logic                    load_en;
  logic                    redirect_take;

  ebpf_slot_decode u_decode (
    .slot     (mem_data),
    .opcode   (d_opc),
    .src      (d_src),
    .dst      (d_dst),
    .offset   (d_off),
    .imm_raw  (d_imm_raw),
    .imm_sext (d_imm_sext)
  );

  assign pc_plus1 = pc + PC_ONE;
  assign pc_plus2 = pc + PC_TWO;

  assign xfer          = valid_q && insn.insn_ready;
  assign load_en       = !valid_q || insn.insn_ready;
  assign redirect_take = redirect_valid &&
                         ((state == ST_FETCH) || (state == ST_FETCH_HI) || (state == ST_DRAIN));

  // Address the slot being fetched: the second LDDW slot in FETCH_HI, pc otherwise.
  // In FETCH_HI pc+1 is always a legal slot, so the truncation cannot wrap.
  always_comb begin
    mem_address = pc[address_size-1:0];
    if (state == ST_FETCH_HI) begin
      mem_address = pc_plus1[address_size-1:0];
    end
  end

  // Fetch FSM together with the output register and the LDDW low-half latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= '0;
      valid_q  <= 1'b0;
      opc_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      off_q    <= '0;
      imm_q    <= '0;
      ipc_q    <= '0;
      lo_src   <= '0;
      lo_dst   <= '0;
      lo_off   <= '0;
      lo_imm   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      // A transfer empties the register unless a load below refills it
      if (xfer) begin
        valid_q <= 1'b0;
      end

      if (redirect_take) begin
        // Wrong-path instruction is dropped even if execute is ready this cycle
        valid_q <= 1'b0;
        pc      <= {1'b0, redirect_pc};
        state   <= ST_FETCH;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              pc    <= {1'b0, start_pc};
              state <= ST_FETCH;
            end
          end

          ST_FETCH: begin
            if (load_en) begin
              if (d_opc == OP_LDDW) begin
                if (pc_plus1 >= MEM_DEPTH) begin
                  state   <= ST_FAULT;
                  fault_q <= 1'b1;
                end else begin
                  lo_src <= d_src;
                  lo_dst <= d_dst;
                  lo_off <= d_off;
                  lo_imm <= d_imm_raw;
                  state  <= ST_FETCH_HI;
                end
              end else begin
                valid_q <= 1'b1;
                opc_q   <= d_opc;
                src_q   <= d_src;
                dst_q   <= d_dst;
                off_q   <= d_off;
                imm_q   <= d_imm_sext;
                ipc_q   <= pc[address_size-1:0];
                if (d_opc == OP_EXIT) begin
                  // EXIT on the last slot leaves pc in place so mem_address never wraps
                  if (pc_plus1 < MEM_DEPTH) begin
                    pc <= pc_plus1;
                  end
                  state <= ST_DRAIN;
                end else if (pc_plus1 >= MEM_DEPTH) begin
                  state   <= ST_FAULT;
                  fault_q <= 1'b1;
                end else begin
                  pc <= pc_plus1;
                end
              end
            end
          end

          ST_FETCH_HI: begin
            if (load_en) begin
              valid_q <= 1'b1;
              opc_q   <= OP_LDDW;
              src_q   <= lo_src;
              dst_q   <= lo_dst;
              off_q   <= lo_off;
              imm_q   <= {d_imm_raw, lo_imm};
              ipc_q   <= pc[address_size-1:0];
              if (pc_plus2 >= MEM_DEPTH) begin
                state   <= ST_FAULT;
                fault_q <= 1'b1;
              end else begin
                pc    <= pc_plus2;
                state <= ST_FETCH;
              end
            end
          end

          ST_DRAIN: begin
            if (xfer) begin
              state    <= ST_HALT;
              halted_q <= 1'b1;
            end
          end

          ST_HALT: begin
            if (start) begin
              pc       <= {1'b0, start_pc};
              halted_q <= 1'b0;
              state    <= ST_FETCH;
            end
          end

          ST_FAULT: begin
            // Terminal until reset; a buffered instruction still drains above
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign insn.insn_valid  = valid_q;
  assign insn.insn_opcode = opc_q;
  assign insn.insn_src    = src_q;
  assign insn.insn_dst    = dst_q;
  assign insn.insn_offset = off_q;
  assign insn.insn_imm    = imm_q;
  assign insn.insn_pc     = ipc_q;

  assign halted    = halted_q;
  assign fault     = fault_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_ebpf_fetch_unit.sv
// Bench for ebpf_fetch_unit: program memory array, a program-walking
// reference model that predicts the sequence of transferred instructions,
// a per-cycle compare process, directed scenarios and randomized programs.
module tb_ebpf_fetch_unit;
  import ebpf_pkg::*;

  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int W     = 108;   // {pc12, opc8, src4, dst4, off16, imm64}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT ----------------
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halted;
  logic          fault;
  fetch_state_t  state_dbg;
  logic          ready = 1'b0;

  logic [63:0] mem [0:DEPTH-1];
  assign mem_data = mem[mem_address];

  ebpf_fetch_unit_if #(.address_size(AW)) bus ();
  assign bus.insn_ready = ready;

  ebpf_fetch_unit #(.data_size(64), .address_size(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .state_dbg      (state_dbg),
    .insn           (bus)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] xlog[$];
  int           xcyc[$];
  bit           exit_seen = 1'b0;
  bit           exp_fault = 1'b0;
  int           start_cyc = 0;
  int           red_cyc   = 0;
  int           prog_base = 0;
  int           prog_len  = 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [11:0] p, input logic [7:0] o,
                                        input logic [3:0] s, input logic [3:0] d,
                                        input logic [15:0] f, input logic [63:0] i);
    return {p, o, s, d, f, i};
  endfunction

  function automatic logic [11:0] f_pc(input logic [W-1:0] v);  return v[107:96]; endfunction
  function automatic logic [7:0]  f_opc(input logic [W-1:0] v); return v[95:88];  endfunction
  function automatic logic [3:0]  f_dst(input logic [W-1:0] v); return v[83:80];  endfunction
  function automatic logic [63:0] f_imm(input logic [W-1:0] v); return v[63:0];   endfunction

  // Reference model: walk the program from p and list every instruction
  // execute must receive, in order, until EXIT or the end of memory.
  function automatic void model_walk(input int start_p);
    int p;
    logic [63:0] s1;
    logic [63:0] s2;
    exp_q.delete();
    exp_fault = 1'b0;
    p = start_p;
    for (int k = 0; k < DEPTH; k++) begin
      if (p >= DEPTH) begin
        exp_fault = 1'b1;
        break;
      end
      s1 = mem[p];
      if (s1[63:56] == 8'h18) begin
        if (p + 1 >= DEPTH) begin
          exp_fault = 1'b1;
          break;
        end
        s2 = mem[p + 1];
        exp_q.push_back(pack(12'(p), s1[63:56], s1[55:52], s1[51:48], s1[47:32],
                             {s2[31:0], s1[31:0]}));
        p += 2;
      end else begin
        exp_q.push_back(pack(12'(p), s1[63:56], s1[55:52], s1[51:48], s1[47:32],
                             {{32{s1[31]}}, s1[31:0]}));
        if (s1[63:56] == 8'h95) break;
        p += 1;
      end
    end
  endfunction

  // ---------------- compare process ----------------
  logic [W-1:0] act_v;
  logic [W-1:0] exp_v;
  logic [W-1:0] prev_v;
  bit           prev_hold = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exit_seen = 1'b0;
      exp_fault = 1'b0;
      prev_hold = 1'b0;
    end else begin
      act_v = pack(bus.insn_pc, bus.insn_opcode, bus.insn_src, bus.insn_dst,
                   bus.insn_offset, bus.insn_imm);
      chk("halted", halted, exit_seen);
      if (prev_hold) chk("hold_stable", {bus.insn_valid, act_v}, {1'b1, prev_v});
      if (bus.insn_valid && ready && !redirect_valid) begin
        xlog.push_back(act_v);
        xcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("xfer_unexpected", act_v, '0);
          if (bus.insn_opcode == 8'h95) exit_seen = 1'b1;
        end else begin
          exp_v = exp_q.pop_front();
          chk("xfer", act_v, exp_v);
          if (f_opc(exp_v) == 8'h95) exit_seen = 1'b1;
        end
      end
      if (redirect_valid) begin
        red_cyc = cyc;
        model_walk(int'(redirect_pc));
      end
      if (start) begin
        exit_seen = 1'b0;
        start_cyc = cyc;
        model_walk(int'(start_pc));
      end
      prev_hold = bus.insn_valid && !ready && !redirect_valid;
      prev_v    = act_v;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    start = 1'b0;
    redirect_valid = 1'b0;
    ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic start_at(input logic [AW-1:0] p);
    xlog.delete();
    xcyc.delete();
    @(posedge clk); #1;
    start_pc = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run until the model says the program is over; rnd enables random
  // backpressure and random redirects inside the current program.
  task automatic run_until_done(input int budget, input bit rnd);
    int  n;
    int  nred;
    bit  done;
    n = 0;
    nred = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      if (rnd) begin
        ready = ($urandom_range(0, 3) != 0);
        if (!exit_seen && nred < 6 && $urandom_range(0, 11) == 0) begin
          redirect_valid = 1'b1;
          redirect_pc = AW'(prog_base + $urandom_range(0, prog_len - 1));
          nred++;
        end
      end else begin
        ready = 1'b1;
      end
      done = (exit_seen && halted) || (exp_fault && fault && !bus.insn_valid);
      n++;
    end
    redirect_valid = 1'b0;
    if (!done) chk("run_timeout", 1'b0, 1'b1);
    chk("model_queue_empty", exp_q.size(), 0);
    chk("fault_flag", fault, exp_fault);
  endtask

  task automatic build_program(input int base, input int len);
    logic [7:0]  ops [9];
    logic [63:0] r;
    int i;
    ops = '{8'hb4, 8'hb7, 8'h07, 8'h15, 8'h1d, 8'hbf, 8'h61, 8'h63, 8'h05};
    prog_base = base;
    prog_len  = len;
    i = 0;
    while (i < len - 1) begin
      r = {$urandom(), $urandom()};
      if (i <= len - 3 && $urandom_range(0, 4) == 0) begin
        mem[base + i] = {8'h18, r[55:0]};
        r = {$urandom(), $urandom()};
        mem[base + i + 1] = {8'h00, r[55:0]};
        i += 2;
      end else begin
        mem[base + i] = {ops[$urandom_range(0, 8)], r[55:0]};
        i += 1;
      end
    end
    mem[base + len - 1] = 64'h9500_0000_0000_0000;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    bit got;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset state
    do_reset();
    #1;
    chk("rst_valid", bus.insn_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_mem_address", mem_address, 12'd0);
    chk("rst_state", state_dbg, ST_IDLE);
    chk("rst_fields", {bus.insn_pc, bus.insn_opcode, bus.insn_imm}, '0);

    // Straight line: mov32 r7,0xa then EXIT
    mem[0] = 64'hb407_0000_0000_000a;
    mem[1] = 64'h9500_0000_0000_0000;
    ready = 1'b1;
    start_at(12'd0);
    run_until_done(50, 1'b0);
    chk("t1_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("t1_pc0", f_pc(xlog[0]), 12'd0);
      chk("t1_opc0", f_opc(xlog[0]), 8'hb4);
      chk("t1_dst0", f_dst(xlog[0]), 4'd7);
      chk("t1_imm0", f_imm(xlog[0]), 64'h0a);
      chk("t1_opc1", f_opc(xlog[1]), 8'h95);
      chk("t1_pc1", f_pc(xlog[1]), 12'd1);
      chk("t1_latency", xcyc[0] - start_cyc, 2);
      chk("t1_throughput", xcyc[1] - xcyc[0], 1);
    end
    repeat (3) begin
      @(posedge clk); #1;
      chk("t1_mem_address_static", mem_address, 12'd2);
    end

    // Backpressure: three instructions and EXIT at 10..13
    mem[10] = 64'hb401_0000_0000_0001;
    mem[11] = 64'hb702_0000_0000_0002;
    mem[12] = 64'h0703_0004_8000_0000;
    mem[13] = 64'h9500_0000_0000_0000;
    ready = 1'b0;
    start_at(12'd10);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.insn_valid;
    end
    chk("t2_first_valid", got, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_stall_mem_address", mem_address, 12'd11);
      chk("t2_stall_pc", bus.insn_pc, 12'd10);
    end
    ready = 1'b1;
    run_until_done(50, 1'b0);
    chk("t2_count", xlog.size(), 4);
    if (xlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_pc_seq", f_pc(xlog[i]), 12'(10 + i));
      for (int i = 0; i < 3; i++) chk("t2_back_to_back", xcyc[i + 1] - xcyc[i], 1);
      chk("t2_sext_imm", f_imm(xlog[2]), 64'hffff_ffff_8000_0000);
    end

    // Taken branch: redirect to 7 while slot 6 is buffered
    mem[5] = 64'h1501_0003_0000_0000;
    mem[6] = 64'hb406_0000_0000_0002;
    mem[7] = 64'h9500_0000_0000_0000;
    ready = 1'b1;
    start_at(12'd5);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.insn_valid && bus.insn_pc == 12'd6) begin
        redirect_pc = 12'd7;
        redirect_valid = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        got = 1'b1;
      end
    end
    chk("t3_slot6_buffered", got, 1'b1);
    run_until_done(50, 1'b0);
    chk("t3_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("t3_pc0", f_pc(xlog[0]), 12'd5);
      chk("t3_target_pc", f_pc(xlog[1]), 12'd7);
      chk("t3_target_opc", f_opc(xlog[1]), 8'h95);
      chk("t3_redirect_latency", xcyc[1] - red_cyc, 2);
    end

    // LDDW merge
    mem[0] = 64'h1801_0000_89ab_cdef;
    mem[1] = 64'h0000_0000_0123_4567;
    mem[2] = 64'h9500_0000_0000_0000;
    start_at(12'd0);
    run_until_done(50, 1'b0);
    chk("t4_count", xlog.size(), 2);
    if (xlog.size() == 2) begin
      chk("t4_opc", f_opc(xlog[0]), 8'h18);
      chk("t4_dst", f_dst(xlog[0]), 4'd1);
      chk("t4_imm", f_imm(xlog[0]), 64'h0123_4567_89ab_cdef);
      chk("t4_pc", f_pc(xlog[0]), 12'd0);
      chk("t4_next_pc", f_pc(xlog[1]), 12'd2);
      chk("t4_latency", xcyc[0] - start_cyc, 3);
    end

    // Sign extension and fault at the last slot
    mem[4095] = 64'hb400_0000_ffff_fffe;
    start_at(12'd4095);
    run_until_done(50, 1'b0);
    chk("t5_count", xlog.size(), 1);
    if (xlog.size() == 1) begin
      chk("t5_imm", f_imm(xlog[0]), 64'hffff_ffff_ffff_fffe);
      chk("t5_pc", f_pc(xlog[0]), 12'd4095);
    end
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_fault", fault, 1'b1);
      chk("t5_no_wrap_address", mem_address, 12'd4095);
      chk("t5_no_valid", bus.insn_valid, 1'b0);
      chk("t5_state", state_dbg, ST_FAULT);
    end

    // Async reset while the second LDDW slot is being read
    do_reset();
    mem[20] = 64'hb703_0000_0000_0033;
    mem[21] = 64'h1802_0000_1111_1111;
    mem[22] = 64'h0000_0000_2222_2222;
    mem[23] = 64'h9500_0000_0000_0000;
    ready = 1'b1;
    start_at(12'd20);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (state_dbg == ST_FETCH_HI);
    end
    chk("t6_reached_fetch_hi", got, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", bus.insn_valid, 1'b0);
    chk("t6_async_state", state_dbg, ST_IDLE);
    chk("t6_async_pc", bus.insn_pc, 12'd0);
    chk("t6_async_opc", bus.insn_opcode, 8'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    ready = 1'b1;
    start_at(12'd20);
    run_until_done(50, 1'b0);
    chk("t6_count", xlog.size(), 3);
    if (xlog.size() == 3) begin
      chk("t6_pc_lddw", f_pc(xlog[1]), 12'd21);
      chk("t6_imm_lddw", f_imm(xlog[1]), 64'h2222_2222_1111_1111);
      chk("t6_pc_exit", f_pc(xlog[2]), 12'd23);
    end

    // Random programs with random backpressure and redirects, restarted from HALT
    for (int it = 0; it < 6; it++) begin
      build_program($urandom_range(100, 3000), $urandom_range(20, 40));
      start_at(AW'(prog_base));
      run_until_done(3000, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
